// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM state encoding for alu_seq.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_SRA  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_NOR  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_SLLV = 4'b1001,
    OP_SRAV = 4'b1010
  } op_e;

  localparam int NFLAGS    = 5;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_ILL   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: bit 0 of B is folded in at start, then one
// further multiplier bit per cycle; o_done marks the cycle the product is final.
module alu_mul_seq #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, i_a, 1'b0};
      r_mplier <= i_b >> 1;
      r_cnt    <= CW'(WIDTH-1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and status flags.
// Define ALU_SEQ_MUL_EN to build opcode 1000 as iterative MUL; otherwise it is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  inp_A,
  input  logic [WIDTH-1:0]  inp_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out,
  output logic [NFLAGS-1:0] flags
);

  state_e              r_state;
  logic [WIDTH-1:0]    r_out;
  logic [NFLAGS-1:0]   r_flags;

  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_res;
  logic                w_carry;
  logic                w_ovf;
  logic                w_ill;
  logic [NFLAGS-1:0]   w_flags;
  logic                w_accept;
  logic                w_is_mul;

  assign w_accept = in_valid && (r_state == S_IDLE);

  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (op)
      OP_AND:  w_res = inp_A & inp_B;
      OP_OR:   w_res = inp_A | inp_B;
      OP_XOR:  w_res = inp_A ^ inp_B;
      OP_NOR:  w_res = ~(inp_A | inp_B);
      OP_ADD: begin
        w_sum   = {1'b0, inp_A} + {1'b0, inp_B};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (inp_A[WIDTH-1] == inp_B[WIDTH-1]) && (w_res[WIDTH-1] != inp_A[WIDTH-1]);
      end
      OP_SUB: begin
        // carry=1 means no borrow, as A + ~B + 1 naturally yields
        w_sum   = {1'b0, inp_A} + {1'b0, ~inp_B} + {{WIDTH{1'b0}}, 1'b1};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (inp_A[WIDTH-1] != inp_B[WIDTH-1]) && (w_res[WIDTH-1] != inp_A[WIDTH-1]);
      end
      OP_SRA:  w_res = $signed(inp_A) >>> 1;
      OP_SLL:  w_res = inp_A << 1;
      OP_SLLV: w_res = inp_A << inp_B[SHW-1:0];
      OP_SRAV: w_res = $signed(inp_A) >>> inp_B[SHW-1:0];
      default: w_ill = 1'b1;
    endcase
    w_flags            = '0;
    w_flags[FLG_ZERO]  = (w_res == '0);
    w_flags[FLG_NEG]   = w_res[WIDTH-1];
    w_flags[FLG_CARRY] = w_carry;
    w_flags[FLG_OVF]   = w_ovf;
    w_flags[FLG_ILL]   = w_ill;
  end

`ifdef ALU_SEQ_MUL_EN
  logic                 w_mul_busy;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_mul_prod;
  logic [NFLAGS-1:0]    w_mul_flags;

  assign w_is_mul = (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (inp_A),
    .i_b       (inp_B),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  always_comb begin
    w_mul_flags            = '0;
    w_mul_flags[FLG_ZERO]  = (w_mul_prod[WIDTH-1:0] == '0);
    w_mul_flags[FLG_NEG]   = w_mul_prod[WIDTH-1];
    w_mul_flags[FLG_OVF]   = |w_mul_prod[2*WIDTH-1:WIDTH];
  end
`else
  assign w_is_mul = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_state <= S_BUSY;
            end else begin
              r_state <= S_DONE;
              r_out   <= w_res;
              r_flags <= w_flags;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_BUSY: begin
          if (w_mul_done) begin
            r_state <= S_DONE;
            r_out   <= w_mul_prod[WIDTH-1:0];
            r_flags <= w_mul_flags;
          end else if (!w_mul_busy) begin
            // multiplier lost its operation; recover rather than hang
            r_state <= S_IDLE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out       = r_out;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] inp_A = '0;
  logic [31:0] inp_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic [4:0]  flags;

  int checks = 0;
  int failures = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .inp_A     (inp_A),
    .inp_B     (inp_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    end
  endtask

  // Present an op, check acceptance latency, result and flags; result is left held.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_out,
                        input logic [4:0] exp_flags, input int exp_lat);
    int n;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1; op = o; inp_A = a; inp_B = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 1'b1, 1'b0);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_flg"}, flags, exp_flags);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_lo"}, out_valid, 1'b0);
    chk({tag, "_rdy_hi"}, in_ready, 1'b1);
  endtask

  initial begin
    #2;
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_out", out, 32'h0);
    chk("rst_flg", flags, 5'h0);
    @(negedge clk);
    rst = 1'b0;

    // flags = {ill, ovf, carry, neg, zero}
    run_op("add_ff", 4'b0010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'b00110, 0); release_out("add_ff");
    run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 0); release_out("add_ovf");
    run_op("sub_ovf", 4'b0100, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01100, 0); release_out("sub_ovf");
    run_op("sub_zero", 4'b0100, 32'h0, 32'h0, 32'h0, 5'b00101, 0); release_out("sub_zero");
    run_op("sub_brw", 4'b0100, 32'h1, 32'h2, 32'hFFFFFFFF, 5'b00010, 0); release_out("sub_brw");
    run_op("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00010, 0); release_out("and");
    run_op("or", 4'b0001, 32'h0000000F, 32'h000000F0, 32'h000000FF, 5'b00000, 0); release_out("or");
    run_op("xor", 4'b0011, 32'h12345678, 32'h12345678, 32'h0, 5'b00001, 0); release_out("xor");
    run_op("nor", 4'b0111, 32'h0, 32'h0, 32'hFFFFFFFF, 5'b00010, 0); release_out("nor");
    run_op("sra", 4'b0101, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 5'b00010, 0); release_out("sra");
    run_op("sll", 4'b0110, 32'h80000001, 32'h0, 32'h00000002, 5'b00000, 0); release_out("sll");
    run_op("srav31", 4'b1010, 32'h80000000, 32'd31, 32'hFFFFFFFF, 5'b00010, 0); release_out("srav31");
    run_op("srav_wrap0", 4'b1010, 32'h12345678, 32'h00000020, 32'h12345678, 5'b00000, 0); release_out("srav_wrap0");
    run_op("sllv_wrap", 4'b1001, 32'h00000001, 32'h00000021, 32'h00000002, 5'b00000, 0); release_out("sllv_wrap");
    run_op("ill_c", 4'b1100, 32'h5, 32'h6, 32'h0, 5'b10001, 0); release_out("ill_c");
    run_op("ill_f", 4'b1111, 32'hFFFFFFFF, 32'h1, 32'h0, 5'b10001, 0); release_out("ill_f");
`ifdef ALU_SEQ_MUL_EN
    run_op("mul_big", 4'b1000, 32'h00010000, 32'h00010000, 32'h0, 5'b01001, 32); release_out("mul_big");
    run_op("mul_7x6", 4'b1000, 32'd7, 32'd6, 32'd42, 5'b00000, 32); release_out("mul_7x6");
    run_op("mul_neg", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 5'b00010, 32); release_out("mul_neg");
`else
    run_op("mul_ill", 4'b1000, 32'd7, 32'd6, 32'h0, 5'b10001, 0); release_out("mul_ill");
`endif

    // back-pressure: result held, new requests ignored
    run_op("bp", 4'b0010, 32'd3, 32'd4, 32'd7, 5'b00000, 0);
    in_valid = 1'b1; op = 4'b0000; inp_A = 32'hFFFFFFFF; inp_B = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", out_valid, 1'b1);
      chk("bp_rdy", in_ready, 1'b0);
      chk("bp_out", out, 32'd7);
      chk("bp_flg", flags, 5'b00000);
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp_out_after", out, 32'd7);

    // reset while an operation is in flight
    @(negedge clk);
    in_valid = 1'b1; op = 4'b1000; inp_A = 32'd9; inp_B = 32'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
    chk("pre_rst_vld", out_valid, 1'b0);
`else
    chk("pre_rst_vld", out_valid, 1'b1);
`endif
    rst = 1'b1;
    #1;
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_out", out, 32'h0);
    chk("arst_flg", flags, 5'h0);
    chk("arst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_vld", out_valid, 1'b0);
    run_op("ill_post_rst", 4'b1100, 32'h1, 32'h1, 32'h0, 5'b10001, 0); release_out("ill_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU: WIDTH-bit datapath, 4-bit opcode (the eight original 3-bit operations kept at their encodings with a leading 0, plus variable shifts and an iterative multiply), registered result with status flags. It sits between an issue stage (valid/ready producer) and a writeback consumer. Single-cycle ops complete one cycle after acceptance; MUL takes WIDTH cycles. Result is held until the consumer accepts it.

## Interface
- WIDTH, 32, datapath width; power of two, 8..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation
- op  in  4  opcode (see Operation)
- inp_A  in  WIDTH  operand A
- inp_B  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  result
- flags  out  5  {illegal, overflow, carry, negative, zero}

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB (A-B), 0101 SRA A by 1, 0110 SLL A by 1, 0111 NOR, 1000 MUL (low WIDTH bits of unsigned A*B), 1001 SLLV A by B[SHW-1:0], 1010 SRAV A by B[SHW-1:0], 1011-1111 illegal.
- FSM: IDLE -> (accept, single-cycle op) -> DONE; IDLE -> (accept, MUL) -> BUSY; BUSY -> (counter==0) -> DONE; DONE -> (out_ready) -> IDLE.
- Accept = in_valid && in_ready; in_ready = (state==IDLE). Inputs ignored otherwise; operands latched at accept.
- out, flags change only on transition into DONE; stable while out_valid && !out_ready.
- zero = (out==0); negative = out[WIDTH-1]; all flags computed on final result.
- ADD: carry = carry-out, overflow = signed overflow. SUB: computed as A+~B+1; carry = carry-out (1 means no borrow), overflow = signed overflow.
- MUL: carry=0; overflow = high WIDTH bits of full product nonzero. All other ops: carry=0, overflow=0.
- Illegal op: out=0, flags=5'b10001, single-cycle.
- Shift amounts wrap modulo WIDTH (only SHW low bits of B used); amount 0 returns A.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, out=0, flags=0, MUL counter=0. Reset mid-BUSY/DONE aborts and discards the operation.
- Single-cycle op accepted at edge k: out_valid high after edge k.
- MUL accepted at edge k: BUSY for WIDTH cycles, one partial-product bit per edge; out_valid high after edge k+WIDTH.
- out_valid && out_ready at edge j: out_valid low after edge j, in_ready high after edge j; next accept no earlier than edge j+1 (no back-to-back bypass).
- out_ready while out_valid=0 is ignored.
- Throughput: one single-cycle op per 2 cycles with out_ready held high.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 1000 is MUL as above; BUSY state and iterative multiplier present.
- Not defined: opcode 1000 treated as illegal (out=0, flags=5'b10001, single-cycle); BUSY state and multiplier are not instantiated.

## Structure
- Package alu_seq_pkg: opcode localparams/enum (OP_AND..OP_SRAV), flag bit indices (FLG_ZERO=0, FLG_NEG=1, FLG_CARRY=2, FLG_OVF=3, FLG_ILL=4), FSM state enum.
- Sub-module alu_mul_seq: shift-add multiplier (start, operands, busy, done, 2*WIDTH product), instantiated only under ALU_SEQ_MUL_EN.
- Single-cycle ops and flag logic stay in alu_seq.

## Test plan
- WIDTH=32, ADD A=32'hFFFFFFFF, B=32'hFFFFFFFF -> out=32'hFFFFFFFE, carry=1, overflow=0, negative=1, out_valid one cycle after accept.
- SUB A=32'h80000000, B=1 -> out=32'h7FFFFFFF, overflow=1, carry=1; SUB A=0, B=0 -> out=0, zero=1, carry=1.
- SRA A=32'hFFFFFFFE -> out=32'hFFFFFFFF; SRAV A=32'h80000000, B=31 -> 32'hFFFFFFFF; SLLV A=1, B=32'h00000021 -> out=2 (amount wraps to 1).
- MUL A=32'h00010000, B=32'h00010000 -> out=0, zero=1, overflow=1, out_valid exactly 32 cycles after accept; MUL 7*6 -> 42, overflow=0.
- Back-pressure: hold out_ready=0 for 5 cycles after result -> out/flags stable, in_ready=0, new in_valid ignored; release -> IDLE next cycle.
- Assert rst mid-MUL (cycle 10 of BUSY) -> immediately out_valid=0, out=0, flags=0, in_ready=1; op 1100 -> out=0, flags=5'b10001.
